// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: streaming one-hot to binary encoder with skid buffer and error counter
module onehot_encoder_pipe #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi,
  input  logic             err_clear,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] enc_idx, sk_idx;
  logic enc_zero, enc_multi, sk_zero, sk_multi;
  logic accept, err_accept, ld_or_in, ld_or_sk, ld_sk;
  // lowest set bit wins; scanning downward lets the last hit be the lowest index
  always_comb begin
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (in_data[i]) enc_idx = IDX_W'(i);
  end
  // clearing the lowest set bit leaves something only when two or more were set
  assign enc_zero   = ~|in_data;
  assign enc_multi  = |(in_data & (in_data - N'(1)));
  // ready and valid decode straight from the state register, so out_ready never reaches in_ready
  assign in_ready   = state != FULL;
  assign out_valid  = state != EMPTY;
  assign accept     = in_valid & in_ready;
  assign err_accept = accept & (enc_zero | enc_multi);
  // buffer occupancy register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else state <= state_nxt;
  // next occupancy and which register loads from where
  always_comb begin
    state_nxt = state;
    ld_or_in  = 1'b0;
    ld_or_sk  = 1'b0;
    ld_sk     = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        ld_or_in  = 1'b1;
      end
      ONE: begin
        if (accept && out_ready) ld_or_in = 1'b1;
        else if (accept) begin
          state_nxt = FULL;
          ld_sk     = 1'b1;
        end else if (out_ready) state_nxt = EMPTY;
      end
      FULL: if (out_ready) begin
        state_nxt = ONE;
        ld_or_sk  = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end
  // output register: takes the new word, or the skid word when the skid drains
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
    end else if (ld_or_in) begin
      out_idx   <= enc_idx;
      out_zero  <= enc_zero;
      out_multi <= enc_multi;
    end else if (ld_or_sk) begin
      out_idx   <= sk_idx;
      out_zero  <= sk_zero;
      out_multi <= sk_multi;
    end
  // skid register: catches the word accepted while the output is held
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sk_idx   <= '0;
      sk_zero  <= 1'b0;
      sk_multi <= 1'b0;
    end else if (ld_sk) begin
      sk_idx   <= enc_idx;
      sk_zero  <= enc_zero;
      sk_multi <= enc_multi;
    end
  // saturating error count; a clear still counts an error accepted in the same cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) err_count <= '0;
    else if (err_clear) err_count <= err_accept ? CNT_W'(1) : '0;
    else if (err_accept && err_count != '1) err_count <= err_count + CNT_W'(1);
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: directed and random stimulus against a queue-based reference model
module tb_onehot_encoder_pipe;
  localparam int N = 8, IW = 3, CW = 4;
  logic clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, err_clear = 1'b0;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid, out_zero, out_multi;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] err_count;
  int checks = 0, errors = 0, err_m = 0;
  logic [4:0] q[$];
  onehot_encoder_pipe #(.N(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_zero(out_zero), .out_multi(out_multi), .err_clear(err_clear), .err_count(err_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] enc(input logic [N-1:0] d);
    int idx = 0, c = 0;
    for (int i = N - 1; i >= 0; i--)
      if (d[i]) begin
        idx = i;
        c++;
      end
    return {idx[2:0], c == 0, c > 1};
  endfunction
  task automatic cycle();
    logic acc, drain, e;
    logic [4:0] w;
    @(negedge clock);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("err_count", err_count, err_m);
    if (q.size() > 0) chk("out_word", {out_idx, out_zero, out_multi}, q[0]);
    w = enc(in_data);
    acc = in_valid && q.size() < 2;
    drain = q.size() > 0 && out_ready;
    e = acc && (w[1] || w[0]);
    if (err_clear) err_m = e ? 1 : 0;
    else if (e && err_m != 15) err_m++;
    if (drain) void'(q.pop_front());
    if (acc) q.push_back(w);
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [N-1:0] d, input logic v, input logic r);
    in_data = d;
    in_valid = v;
    out_ready = r;
    cycle();
  endtask
  initial begin
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_word", {out_idx, out_zero, out_multi}, 0);
    chk("rst_err", err_count, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < N; i++) send(8'(1) << i, 1, 1);
    send(0, 0, 1);
    send(0, 1, 1);
    send(8'h0C, 1, 1);
    send(0, 0, 1);
    send(0, 0, 1);
    chk("malformed_err", err_count, 2);
    send(8'h04, 1, 1);
    send(8'h10, 1, 0);
    send(8'h40, 1, 0);
    chk("bp_full_in_ready", in_ready, 0);
    send(8'h40, 1, 0);
    send(8'h40, 1, 1);
    send(8'h40, 1, 1);
    send(8'h80, 1, 1);
    send(0, 0, 1);
    send(0, 0, 1);
    for (int i = 0; i < 17; i++) send(0, 1, 1);
    chk("sat_err", err_count, 15);
    err_clear = 1'b1;
    send(0, 1, 1);
    send(0, 0, 1);
    err_clear = 1'b0;
    send(8'h01, 1, 0);
    send(8'h02, 1, 0);
    in_valid = 1'b0;
    reset_n = 1'b0;
    q.delete();
    err_m = 0;
    @(negedge clock);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_err", err_count, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      err_clear = $urandom_range(0, 15) == 0;
      send($urandom_range(0, 1) ? 8'(1) << $urandom_range(0, 7) : 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    err_clear = 1'b0;
    send(0, 0, 1);
    send(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_encoder_pipe.md
# onehot_encoder_pipe

Streaming one-hot-to-binary encoder: the inverse of the decoder block driven by the decoder_in interface. It accepts one-hot words over a valid/ready handshake, emits the binary index plus zero/multi-hot flags one cycle later, and keeps a saturating count of malformed words. It sits between a stimulus or loopback source and the decoder's input agent, closing the decode/encode loop for self-checking benches. Full throughput is sustained under output backpressure via a one-entry skid buffer.

## Interface
- N, default 8: width of the one-hot input word; N ≥ 2.
- IDX_W, default $clog2(N): width of the binary index output.
- CNT_W, default 16: width of the error counter.

- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept; a word transfers when in_valid && in_ready.
- in_data  in  N  one-hot input word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts; a result transfers when out_valid && out_ready.
- out_idx  out  IDX_W  index of the lowest set bit of the word; 0 when the word is zero.
- out_zero  out  1  word had no bits set.
- out_multi  out  1  word had two or more bits set.
- err_clear  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of accepted words with out_zero or out_multi.

## Operation
- Encoding, combinational on in_data: idx = lowest set bit position; zero = ~|in_data; multi = popcount > 1. Bits at index ≥ N do not exist; IDX_W truncation is never needed.
- Storage: output register (OR) plus one skid register (SK), each holding {idx, zero, multi} and a valid bit.
- in_ready = ~SK.valid, driven from a register with no combinational path from out_ready.
- Accept with OR empty, or with OR draining this cycle: the word goes to OR.
- Accept while OR is held (out_valid && ~out_ready): the word goes to SK; in_ready drops the next cycle.
- OR drains while SK is full: SK moves to OR, SK empties, and in_ready rises the next cycle.
- Buffer states are EMPTY (OR, SK invalid), ONE (OR valid), and FULL (both valid). FULL never accepts.
- Order is strictly preserved; no word is dropped or duplicated.
- err_count increments by 1 on each accepted word with zero or multi set. It saturates at all-ones and holds.
- err_clear asserted in the same cycle as an erroneous accept gives err_count = 1 in the next cycle.
- err_clear with no erroneous accept gives err_count = 0.

## Timing
- Reset (async assert, sync-release by the integrator) sets these values: out_valid=0, out_idx=0, out_zero=0, out_multi=0, in_ready=1, err_count=0, SK empty.
- Latency: a word accepted in cycle t appears on out_* in cycle t+1 when OR was empty or draining.
- Throughput: 1 word/cycle while out_ready=1.
- out_* are stable while out_valid && ~out_ready; out_valid never drops without a transfer.
- in_ready may fall only the cycle after an accept into SK; it returns 1 the cycle after SK drains.
- Reset mid-operation discards OR and SK contents immediately; the output handshake signals are not completed.

## Test plan
- Walking one, N=8, out_ready=1: in_data 8'h01, 8'h02 … 8'h80 back-to-back. Required: out_idx 0..7 on consecutive cycles starting 1 cycle after the first accept, zero=multi=0, err_count=0.
- Malformed words: 8'h00 then 8'h0C. Required: first gives zero=1, idx=0; second gives multi=1, idx=2. err_count=2.
- Backpressure: hold out_ready=0 for 3 cycles during a 4-word stream. Required: OR holds word0 and SK takes word1, then in_ready=0. After release, words 0–3 emerge in order with no loss.
- Saturation, CNT_W=4: 17 words of 8'h00. Required: err_count reaches 4'hF and stays. err_clear together with an error gives 1.
- Reset mid-stream: assert reset_n=0 in FULL state. Required: the next cycle shows out_valid=0, in_ready=1, err_count=0, and fresh words encode correctly after release.
